i2c_slave_target: RTL and testbench

- I2C target (slave) engine; the responder counterpart to our I2C master. It lets the design be addressed by an external master, or a second instance of our master in loopback benches.
- Oversamples SCL/SDA on the core clock and detects START/STOP.
- Matches a 7-bit address, ACKs/NACKs, and shifts write bytes out to a byte sink.
- Shifts read bytes in from a byte source, stretching SCL while no read byte is available.

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_line_sync.sv | 39 +++
 rtl/i2c_slave_target.sv | 189 ++++++++++++++++++
 tb/tb_i2c_slave_target.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C target types and bus constants
package i2c_pkg;

    localparam int         I2C_ADDR_W = 7;
    localparam logic       I2C_ACK    = 1'b0;
    localparam logic       I2C_NACK   = 1'b1;
    localparam logic [2:0] BIT_MSB    = 3'd7;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_LOAD,
        RD_DATA,
        RD_ACK,
        WAIT_STOP
    } i2c_state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// rtl/i2c_line_sync.sv - SCL/SDA synchronizer with edge and START/STOP detection
module i2c_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_sync
);

    // [0],[1] form the synchronizer; [2] is the delayed copy for edge detection.
    // Reset to 1 so an idle (pulled-up) bus produces no false edges.
    logic [2:0] scl_q;
    logic [2:0] sda_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_q     <= 3'b111;
            sda_q     <= 3'b111;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            scl_q     <= {scl_q[1:0], scl};
            sda_q     <= {sda_q[1:0], sda};
            scl_rise  <= scl_q[1] & ~scl_q[2];
            scl_fall  <= ~scl_q[1] & scl_q[2];
            start_det <= scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
            stop_det  <= scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
        end
    end

    assign sda_sync = sda_q[2];

endmodule

// File: rtl/i2c_slave_target.sv
// rtl/i2c_slave_target.sv - I2C target engine with address match, byte sink/source and clock stretching
module i2c_slave_target
    import i2c_pkg::*;
#(
    parameter int                    DATA_SIZE  = 8,
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h50
) (
    input  logic                 i2c_core_clk_i,
    input  logic                 reset_i,
    input  logic                 enable_i,
    input  logic                 scl_i,
    input  logic                 sda_i,
    output logic                 scl_oe_o,
    output logic                 sda_oe_o,
    output logic [DATA_SIZE-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_full_i,
    input  logic [DATA_SIZE-1:0] tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    output logic                 start_o,
    output logic                 stop_o,
    output logic                 addr_match_o,
    output logic                 rw_o,
    output logic                 nack_o,
    output logic                 busy_o
);

    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
    logic sda_sync;

    i2c_line_sync u_line_sync (
        .clk       (i2c_core_clk_i),
        .reset     (reset_i),
        .scl       (scl_i),
        .sda       (sda_i),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_sync  (sda_sync)
    );

    i2c_state_e           state;
    logic [DATA_SIZE-1:0] shreg;
    logic [2:0]           bit_cnt;
    logic                 byte_done;
    logic                 addr_hit;

    always_ff @(posedge i2c_core_clk_i) begin
        if (reset_i) begin
            state        <= IDLE;
            shreg        <= '0;
            bit_cnt      <= '0;
            byte_done    <= 1'b0;
            addr_hit     <= 1'b0;
            scl_oe_o     <= 1'b0;
            sda_oe_o     <= 1'b0;
            rx_data_o    <= '0;
            rx_valid_o   <= 1'b0;
            tx_ready_o   <= 1'b0;
            start_o      <= 1'b0;
            stop_o       <= 1'b0;
            addr_match_o <= 1'b0;
            rw_o         <= 1'b0;
            nack_o       <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            rx_valid_o   <= 1'b0;
            tx_ready_o   <= 1'b0;
            start_o      <= 1'b0;
            stop_o       <= 1'b0;
            addr_match_o <= 1'b0;
            nack_o       <= 1'b0;

            if (!enable_i) begin
                state    <= IDLE;
                scl_oe_o <= 1'b0;
                sda_oe_o <= 1'b0;
                busy_o   <= 1'b0;
            end else if (stop_det) begin
                state    <= IDLE;
                stop_o   <= 1'b1;
                busy_o   <= 1'b0;
                scl_oe_o <= 1'b0;
                sda_oe_o <= 1'b0;
            end else if (start_det) begin
                state     <= ADDR;
                start_o   <= 1'b1;
                busy_o    <= 1'b1;
                bit_cnt   <= BIT_MSB;
                byte_done <= 1'b0;
                scl_oe_o  <= 1'b0;
                sda_oe_o  <= 1'b0;
            end else begin
                case (state)
                    ADDR, WR_DATA: begin
                        // Bits are shifted on SCL rise; the byte is acted on at the following fall.
                        if (scl_rise && !byte_done) begin
                            shreg <= {shreg[DATA_SIZE-2:0], sda_sync};
                            if (bit_cnt == 3'd0) begin
                                byte_done <= 1'b1;
                                if (state == ADDR) begin
                                    addr_hit <= (shreg[I2C_ADDR_W-1:0] == SLAVE_ADDR);
                                    rw_o     <= sda_sync;
                                end
                            end else begin
                                bit_cnt <= bit_cnt - 3'd1;
                            end
                        end else if (scl_fall && byte_done) begin
                            byte_done <= 1'b0;
                            if (state == ADDR) begin
                                if (addr_hit) begin
                                    sda_oe_o     <= ~I2C_ACK;
                                    addr_match_o <= 1'b1;
                                    state        <= ADDR_ACK;
                                end else begin
                                    state <= WAIT_STOP;
                                end
                            end else if (!rx_full_i) begin
                                rx_data_o  <= shreg;
                                rx_valid_o <= 1'b1;
                                sda_oe_o   <= ~I2C_ACK;
                                state      <= WR_ACK;
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end
                    end
                    ADDR_ACK, WR_ACK: begin
                        if (scl_fall) begin
                            sda_oe_o <= 1'b0;
                            bit_cnt  <= BIT_MSB;
                            state    <= (state == ADDR_ACK && rw_o) ? RD_LOAD : WR_DATA;
                        end
                    end
                    RD_LOAD: begin
                        // While stretching, SCL stays held this cycle and is released once the MSB is on SDA.
                        if (tx_valid_i) begin
                            shreg      <= tx_data_i;
                            tx_ready_o <= 1'b1;
                            sda_oe_o   <= ~tx_data_i[DATA_SIZE-1];
                            bit_cnt    <= BIT_MSB;
                            state      <= RD_DATA;
                        end else begin
                            scl_oe_o <= 1'b1;
                        end
                    end
                    RD_DATA: begin
                        scl_oe_o <= 1'b0;
                        if (scl_fall) begin
                            if (bit_cnt == 3'd0) begin
                                sda_oe_o  <= 1'b0;
                                byte_done <= 1'b0;
                                state     <= RD_ACK;
                            end else begin
                                sda_oe_o <= ~shreg[DATA_SIZE-2];
                                shreg    <= {shreg[DATA_SIZE-2:0], 1'b0};
                                bit_cnt  <= bit_cnt - 3'd1;
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            if (sda_sync == I2C_NACK) begin
                                nack_o <= 1'b1;
                                state  <= WAIT_STOP;
                            end else begin
                                byte_done <= 1'b1;
                            end
                        end else if (scl_fall && byte_done) begin
                            byte_done <= 1'b0;
                            state     <= RD_LOAD;
                        end
                    end
                    IDLE, WAIT_STOP: begin
                        scl_oe_o <= 1'b0;
                        sda_oe_o <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_target.sv
// tb/tb_i2c_slave_target.sv - directed bus-master bench for i2c_slave_target
module tb_i2c_slave_target;
    import i2c_pkg::*;

    localparam int Q = 10;
    localparam int H = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       rx_full = 1'b0;
    logic       tx_en = 1'b0;
    logic       scl_line, sda_line;
    logic       scl_oe, sda_oe, rx_valid, tx_ready, tx_valid;
    logic       start_p, stop_p, match_p, rw, nack_p, busy;
    logic [7:0] rx_data, tx_data;

    logic [7:0] tx_q [0:15];
    logic [7:0] rx_log [0:31];
    int tx_cnt = 0, tx_idx = 0;
    int n_rx = 0, n_txr = 0, n_start = 0, n_stop = 0, n_match = 0, n_nack = 0;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    assign scl_line = scl_m & ~scl_oe;
    assign sda_line = sda_m & ~sda_oe;
    assign tx_data  = tx_q[tx_idx[3:0]];
    assign tx_valid = tx_en && (tx_idx != tx_cnt);

    i2c_slave_target dut (
        .i2c_core_clk_i (clk),
        .reset_i        (reset),
        .enable_i       (enable),
        .scl_i          (scl_line),
        .sda_i          (sda_line),
        .scl_oe_o       (scl_oe),
        .sda_oe_o       (sda_oe),
        .rx_data_o      (rx_data),
        .rx_valid_o     (rx_valid),
        .rx_full_i      (rx_full),
        .tx_data_i      (tx_data),
        .tx_valid_i     (tx_valid),
        .tx_ready_o     (tx_ready),
        .start_o        (start_p),
        .stop_o         (stop_p),
        .addr_match_o   (match_p),
        .rw_o           (rw),
        .nack_o         (nack_p),
        .busy_o         (busy)
    );

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_log[n_rx] = rx_data;
            n_rx++;
        end
        if (tx_ready) begin
            tx_idx++;
            n_txr++;
        end
        if (start_p) n_start++;
        if (stop_p)  n_stop++;
        if (match_p) n_match++;
        if (nack_p)  n_nack++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_high();
        int n = 0;
        while (scl_line !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            total++;
            bad++;
            $error("FAIL scl_release_timeout observed=0 expected=1");
        end
    endtask

    task automatic bus_start();
        sda_m = 1'b1; wait_cyc(Q);
        scl_m = 1'b1; wait_high(); wait_cyc(H);
        sda_m = 1'b0; wait_cyc(H);
        scl_m = 1'b0; wait_cyc(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wait_cyc(Q);
        scl_m = 1'b1; wait_high(); wait_cyc(H);
        sda_m = 1'b1; wait_cyc(H);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; wait_cyc(Q);
        scl_m = 1'b1; wait_high(); wait_cyc(H);
        scl_m = 1'b0; wait_cyc(Q);
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; wait_cyc(Q);
        scl_m = 1'b1; wait_high(); wait_cyc(H / 2);
        b = sda_line; wait_cyc(H / 2);
        scl_m = 1'b0; wait_cyc(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic b;
        for (int i = 0; i < 8; i++) begin
            recv_bit(b);
            d = {d[6:0], b};
        end
        send_bit(mack);
    endtask

    task automatic push_tx(input logic [7:0] d);
        tx_q[tx_cnt] = d;
        tx_cnt++;
    endtask

    initial begin
        logic       ack, b;
        logic [7:0] d;
        int b_rx, b_txr, b_start, b_stop, b_match, b_nack, ok;

        for (int i = 0; i < 16; i++) tx_q[i] = 8'h00;
        wait_cyc(4);
        check("reset_outputs", {scl_oe, sda_oe, rx_data, rx_valid, tx_ready, start_p,
                                stop_p, match_p, rw, nack_p, busy}, 32'h0);
        check("reset_state", dut.state, IDLE);
        reset = 1'b0;
        enable = 1'b1;
        wait_cyc(4);

        // Write 0x50/W, 0xA5, 0x3C.
        b_rx = n_rx; b_match = n_match; b_stop = n_stop;
        bus_start();
        check("wr_busy", busy, 1);
        write_byte(8'hA0, ack); check("wr_addr_ack", ack, 0);
        check("wr_rw", rw, 0);
        write_byte(8'hA5, ack); check("wr_ack0", ack, 0);
        write_byte(8'h3C, ack); check("wr_ack1", ack, 0);
        bus_stop();
        check("wr_match_cnt", n_match - b_match, 1);
        check("wr_rx_cnt", n_rx - b_rx, 2);
        check("wr_rx0", rx_log[b_rx], 8'hA5);
        check("wr_rx1", rx_log[b_rx + 1], 8'h3C);
        check("wr_stop_cnt", n_stop - b_stop, 1);
        check("wr_busy_end", busy, 0);

        // Wrong address 0x51/W.
        b_rx = n_rx; b_match = n_match;
        bus_start();
        write_byte(8'hA2, ack); check("miss_addr_nack", ack, 1);
        write_byte(8'h77, ack); check("miss_data_nack", ack, 1);
        check("miss_state", dut.state, WAIT_STOP);
        check("miss_match_cnt", n_match - b_match, 0);
        check("miss_rx_cnt", n_rx - b_rx, 0);
        bus_stop();
        check("miss_state_end", dut.state, IDLE);

        // Read 0xC3 (ACK) then 0x81 (NACK).
        b_txr = n_txr; b_nack = n_nack;
        push_tx(8'hC3); push_tx(8'h81); tx_en = 1'b1;
        bus_start();
        write_byte(8'hA1, ack); check("rd_addr_ack", ack, 0);
        check("rd_rw", rw, 1);
        read_byte(1'b0, d); check("rd_byte0", d, 8'hC3);
        read_byte(1'b1, d); check("rd_byte1", d, 8'h81);
        bus_stop();
        check("rd_txr_cnt", n_txr - b_txr, 2);
        check("rd_nack_cnt", n_nack - b_nack, 1);

        // Read with source empty for 200 cycles: clock stretch.
        tx_en = 1'b0; push_tx(8'h5A);
        bus_start();
        write_byte(8'hA1, ack); check("st_addr_ack", ack, 0);
        sda_m = 1'b1; wait_cyc(Q);
        scl_m = 1'b1;
        ok = 1;
        repeat (200) begin
            @(negedge clk);
            if (scl_oe !== 1'b1 || scl_line !== 1'b0) ok = 0;
        end
        check("st_hold", ok, 1);
        tx_en = 1'b1;
        @(negedge clk);
        check("st_tx_ready", tx_ready, 1);
        check("st_msb_drive", sda_oe, 1);
        check("st_scl_still_held", scl_oe, 1);
        @(negedge clk);
        check("st_scl_release", scl_oe, 0);
        wait_high(); wait_cyc(H / 2);
        d = {7'd0, sda_line}; wait_cyc(H / 2);
        scl_m = 1'b0; wait_cyc(Q);
        for (int i = 0; i < 7; i++) begin
            recv_bit(b);
            d = {d[6:0], b};
        end
        send_bit(1'b1);
        check("st_byte", d, 8'h5A);
        bus_stop();

        // Write 0x11, repeated START, read one byte.
        b_rx = n_rx; b_txr = n_txr; b_start = n_start;
        push_tx(8'hE7);
        bus_start();
        write_byte(8'hA0, ack); check("rs_waddr_ack", ack, 0);
        write_byte(8'h11, ack); check("rs_wdata_ack", ack, 0);
        check("rs_rw0", rw, 0);
        bus_start();
        write_byte(8'hA1, ack); check("rs_raddr_ack", ack, 0);
        check("rs_rw1", rw, 1);
        read_byte(1'b1, d); check("rs_rbyte", d, 8'hE7);
        bus_stop();
        check("rs_start_cnt", n_start - b_start, 2);
        check("rs_rx_cnt", n_rx - b_rx, 1);
        check("rs_rx_data", rx_log[b_rx], 8'h11);
        check("rs_txr_cnt", n_txr - b_txr, 1);

        // Sink full during first data byte.
        b_rx = n_rx;
        rx_full = 1'b1;
        bus_start();
        write_byte(8'hA0, ack); check("full_addr_ack", ack, 0);
        write_byte(8'h42, ack); check("full_nack", ack, 1);
        check("full_rx_cnt", n_rx - b_rx, 0);
        check("full_state", dut.state, WAIT_STOP);
        rx_full = 1'b0;
        bus_stop();

        // Reset in the middle of a read byte that drives SDA low.
        push_tx(8'h00);
        bus_start();
        write_byte(8'hA1, ack); check("rst_addr_ack", ack, 0);
        for (int i = 0; i < 3; i++) recv_bit(b);
        check("rst_pre_sda", sda_oe, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_sda_release", sda_oe, 0);
        check("rst_scl_release", scl_oe, 0);
        check("rst_state", dut.state, IDLE);
        check("rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        bus_stop();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
